// File: rtl/alu_pkg.sv
// Shared constants for the ALU board: operand/opcode widths, the UART frame
// layout and the serializer state encoding.
package alu_pkg;

   localparam int NB_DATA     = 4;
   localparam int NB_OP       = 6;
   localparam int FRAME_BYTES = 5;

   localparam logic [7:0] FRAME_HDR = 8'hA5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } txState_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 serializer for one byte, LSB first. A start strobe seen during the last
// stop-bit cycle chains the next byte with no idle gap.
module uart_tx_byte #(
   parameter int CLKS_PER_BIT = 434,
   parameter int NB_BAUD      = $clog2(CLKS_PER_BIT)
) (
   input  logic       clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_byte,
   input  logic       i_start,
   output logic       o_tx,
   output logic       o_busy,
   output logic       o_byteDone
);
   import alu_pkg::*;

   txState_t           r_state;
   txState_t           w_nextState;
   logic [NB_BAUD-1:0] r_baudCnt;
   logic [2:0]         r_bitIdx;
   logic [7:0]         r_shift;
   logic               r_tx;
   logic               w_nextTx;
   logic               w_load;
   logic               w_baudEnd;

   assign w_baudEnd  = (r_baudCnt == NB_BAUD'(CLKS_PER_BIT - 1));
   assign o_byteDone = (r_state == ST_STOP) && w_baudEnd;
   assign o_busy     = (r_state != ST_IDLE);
   assign o_tx       = r_tx;

   always_comb begin
      w_nextState = r_state;
      w_nextTx    = r_tx;
      w_load      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_nextState = ST_START;
               w_nextTx    = 1'b0;
               w_load      = 1'b1;
            end
         end
         ST_START: begin
            if (w_baudEnd) begin
               w_nextState = ST_DATA;
               w_nextTx    = r_shift[0];
            end
         end
         ST_DATA: begin
            if (w_baudEnd) begin
               if (r_bitIdx == 3'd7) begin
                  w_nextState = ST_STOP;
                  w_nextTx    = 1'b1;
               end else begin
                  w_nextTx = r_shift[r_bitIdx + 3'd1];
               end
            end
         end
         ST_STOP: begin
            if (w_baudEnd) begin
               if (i_start) begin
                  w_nextState = ST_START;
                  w_nextTx    = 1'b0;
                  w_load      = 1'b1;
               end else begin
                  w_nextState = ST_IDLE;
                  w_nextTx    = 1'b1;
               end
            end
         end
         default: begin
            w_nextState = ST_IDLE;
            w_nextTx    = 1'b1;
         end
      endcase
   end

   // The baud counter free-runs while a byte is in flight and wraps at each bit boundary.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= ST_IDLE;
         r_tx      <= 1'b1;
         r_baudCnt <= '0;
         r_bitIdx  <= '0;
         r_shift   <= '0;
      end else begin
         r_state <= w_nextState;
         r_tx    <= w_nextTx;
         if (w_load) begin
            r_shift <= i_byte;
         end
         if (r_state == ST_IDLE || w_baudEnd) begin
            r_baudCnt <= '0;
         end else begin
            r_baudCnt <= r_baudCnt + NB_BAUD'(1);
         end
         if (r_state == ST_START) begin
            r_bitIdx <= '0;
         end else if (r_state == ST_DATA && w_baudEnd) begin
            r_bitIdx <= r_bitIdx + 3'd1;
         end
      end
   end

endmodule

// File: rtl/alu_uart_tx.sv
// Snapshots operands, opcode and ALU result on a send request and transmits
// them as a 5-byte UART frame: header, A, B, op, result.
module alu_uart_tx #(
   parameter int NB_DATA      = alu_pkg::NB_DATA,
   parameter int NB_OP        = alu_pkg::NB_OP,
   parameter int CLKS_PER_BIT = 434,
   parameter int NB_BAUD      = $clog2(CLKS_PER_BIT)
) (
   input  logic               clk,
   input  logic               i_rst_n,
   input  logic [NB_DATA-1:0] i_datoA,
   input  logic [NB_DATA-1:0] i_datoB,
   input  logic [NB_OP-1:0]   i_op,
   input  logic [NB_DATA-1:0] i_result,
   input  logic               i_send,
   output logic               o_tx,
   output logic               o_busy,
   output logic               o_done
);
   import alu_pkg::*;

   logic [NB_DATA-1:0] r_datoA;
   logic [NB_DATA-1:0] r_datoB;
   logic [NB_OP-1:0]   r_op;
   logic [NB_DATA-1:0] r_result;
   logic [2:0]         r_byteIdx;
   logic               r_busy;
   logic               r_done;

   logic               w_byteDone;
   logic               w_txBusy;
   logic               w_lastByte;
   logic               w_frameStart;
   logic               w_nextStart;
   logic               w_frameEnd;
   logic               w_startByte;
   logic [7:0]         w_txByte;

   assign w_lastByte   = (r_byteIdx == 3'(FRAME_BYTES - 1));
   assign w_frameStart = i_send && !r_busy && !w_txBusy;
   assign w_nextStart  = r_busy && w_byteDone && !w_lastByte;
   assign w_frameEnd   = r_busy && w_byteDone && w_lastByte;
   assign w_startByte  = w_frameStart || w_nextStart;

   // The serializer latches the byte on its start strobe, so the mux presents the
   // byte that follows the current index; a fresh frame always opens with the header.
   always_comb begin
      w_txByte = FRAME_HDR;
      if (r_busy) begin
         case (r_byteIdx + 3'd1)
            3'd1:    w_txByte = 8'(r_datoA);
            3'd2:    w_txByte = 8'(r_datoB);
            3'd3:    w_txByte = 8'(r_op);
            3'd4:    w_txByte = 8'(r_result);
            default: w_txByte = FRAME_HDR;
         endcase
      end
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_datoA   <= '0;
         r_datoB   <= '0;
         r_op      <= '0;
         r_result  <= '0;
         r_byteIdx <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= w_frameEnd;
         if (w_frameStart) begin
            r_datoA   <= i_datoA;
            r_datoB   <= i_datoB;
            r_op      <= i_op;
            r_result  <= i_result;
            r_byteIdx <= '0;
            r_busy    <= 1'b1;
         end else if (w_nextStart) begin
            r_byteIdx <= r_byteIdx + 3'd1;
         end else if (w_frameEnd) begin
            r_busy <= 1'b0;
         end
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .NB_BAUD      (NB_BAUD)
   ) u_txByte (
      .clk        (clk),
      .i_rst_n    (i_rst_n),
      .i_byte     (w_txByte),
      .i_start    (w_startByte),
      .o_tx       (o_tx),
      .o_busy     (w_txBusy),
      .o_byteDone (w_byteDone)
   );

   assign o_busy = r_busy;
   assign o_done = r_done;

endmodule
